// File: rtl/pattern_transmitter.sv
// Serial pattern generator: shifts a WIDTH-bit pattern out MSB-first with
// programmable frame repeats and a fixed idle gap between frames.
module pattern_transmitter #(
   parameter int unsigned       WIDTH           = 8,
   parameter logic [WIDTH-1:0]  DEFAULT_PATTERN = 8'b10110101,
   parameter int unsigned       GAP_CYCLES      = 0,
   parameter int unsigned       REP_W           = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] pattern_in,
   input  logic             start,
   input  logic [REP_W-1:0] repeat_count,
   input  logic             abort,
   output logic             sequence_out,
   output logic             bit_valid,
   output logic             ready,
   output logic             done
);

   localparam int unsigned CNT_W    = $clog2(WIDTH);
   localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   pattern_q, pattern_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [REP_W-1:0]   frame_q, frame_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               seq_q, seq_d;
   logic               valid_q, valid_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic               accept;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pattern_q <= DEFAULT_PATTERN;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         frame_q   <= '0;
         gap_q     <= '0;
         seq_q     <= 1'b0;
         valid_q   <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         frame_q   <= frame_d;
         gap_q     <= gap_d;
         seq_q     <= seq_d;
         valid_q   <= valid_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic; outputs lag the state by one cycle so the first bit
   // appears one cycle after start is accepted.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      frame_d   = frame_q;
      gap_d     = gap_q;
      seq_d     = 1'b0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      accept    = (state_q == S_IDLE) && ready_q;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (load) pattern_d = pattern_in;
               if (start) begin
                  shift_d   = load ? pattern_in : pattern_q;
                  frame_d   = repeat_count;
                  bit_cnt_d = CNT_W'(WIDTH - 1);
                  state_d   = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            seq_d     = shift_q[WIDTH-1];
            valid_d   = 1'b1;
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 1'b1;
            if (bit_cnt_q == '0) begin
               bit_cnt_d = CNT_W'(WIDTH - 1);
               if (frame_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  frame_d = frame_q - 1'b1;
                  shift_d = pattern_q;
                  if (GAP_CYCLES != 0) begin
                     state_d = S_GAP;
                     gap_d   = GAP_W'(GAP_LOAD);
                  end
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - 1'b1;
            if (gap_q == '0) state_d = S_SHIFT;
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         seq_d     = 1'b0;
         valid_d   = 1'b0;
         done_d    = 1'b0;
         bit_cnt_d = '0;
         frame_d   = '0;
         gap_d     = '0;
      end

      // ready stays low during the done pulse, rises the cycle after
      ready_d = (state_d == S_IDLE) && ((state_q != S_DONE) || abort);
   end

   assign sequence_out = seq_q;
   assign bit_valid    = valid_q;
   assign ready        = ready_q;
   assign done         = done_q;

endmodule

// File: tb/tb_pattern_transmitter.sv
// Directed bench for pattern_transmitter: one instance back-to-back (no gap),
// one with a two-cycle inter-frame gap.
module tb_pattern_transmitter;

   logic       clk;
   int         tests;
   int         fails;

   logic       a_rst, a_load, a_start, a_abort;
   logic [7:0] a_pat;
   logic [3:0] a_rep;
   logic       a_seq, a_bv, a_ready, a_done;

   logic       b_rst, b_load, b_start, b_abort;
   logic [7:0] b_pat;
   logic [3:0] b_rep;
   logic       b_seq, b_bv, b_ready, b_done;

   pattern_transmitter #(.WIDTH(8), .DEFAULT_PATTERN(8'b10110101), .GAP_CYCLES(0), .REP_W(4)) dut_a (
      .clk(clk), .reset(a_rst), .load(a_load), .pattern_in(a_pat), .start(a_start),
      .repeat_count(a_rep), .abort(a_abort), .sequence_out(a_seq), .bit_valid(a_bv),
      .ready(a_ready), .done(a_done));

   pattern_transmitter #(.WIDTH(8), .DEFAULT_PATTERN(8'b10110101), .GAP_CYCLES(2), .REP_W(4)) dut_b (
      .clk(clk), .reset(b_rst), .load(b_load), .pattern_in(b_pat), .start(b_start),
      .repeat_count(b_rep), .abort(b_abort), .sequence_out(b_seq), .bit_valid(b_bv),
      .ready(b_ready), .done(b_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1;
      step(); step();
      tests += 8;
      if (a_seq !== 1'b0)   begin fails++; $display("FAIL reset_a_seq got %b want 0", a_seq); end
      if (a_bv !== 1'b0)    begin fails++; $display("FAIL reset_a_bv got %b want 0", a_bv); end
      if (a_done !== 1'b0)  begin fails++; $display("FAIL reset_a_done got %b want 0", a_done); end
      if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_a_ready got %b want 1", a_ready); end
      if (b_seq !== 1'b0)   begin fails++; $display("FAIL reset_b_seq got %b want 0", b_seq); end
      if (b_bv !== 1'b0)    begin fails++; $display("FAIL reset_b_bv got %b want 0", b_bv); end
      if (b_done !== 1'b0)  begin fails++; $display("FAIL reset_b_done got %b want 0", b_done); end
      if (b_ready !== 1'b1) begin fails++; $display("FAIL reset_b_ready got %b want 1", b_ready); end
      a_rst = 1'b0; b_rst = 1'b0;
      step();
   endtask

   task automatic test_default_frame();
      logic [7:0] exp;
      exp = 8'b10110101;
      a_start = 1'b1; a_rep = 4'd0;
      step();
      a_start = 1'b0;
      tests += 2;
      if (a_ready !== 1'b0) begin fails++; $display("FAIL dflt_prime_ready got %b want 0", a_ready); end
      if (a_bv !== 1'b0)    begin fails++; $display("FAIL dflt_prime_bv got %b want 0", a_bv); end
      for (int i = 0; i < 8; i++) begin
         step();
         tests += 2;
         if (a_seq !== exp[7-i]) begin fails++; $display("FAIL dflt_bit%0d got %b want %b", i, a_seq, exp[7-i]); end
         if (a_bv !== 1'b1)      begin fails++; $display("FAIL dflt_bv%0d got %b want 1", i, a_bv); end
      end
      step();
      tests += 3;
      if (a_done !== 1'b1)  begin fails++; $display("FAIL dflt_done got %b want 1", a_done); end
      if (a_ready !== 1'b0) begin fails++; $display("FAIL dflt_done_ready got %b want 0", a_ready); end
      if (a_bv !== 1'b0)    begin fails++; $display("FAIL dflt_done_bv got %b want 0", a_bv); end
      step();
      tests += 2;
      if (a_done !== 1'b0)  begin fails++; $display("FAIL dflt_post_done got %b want 0", a_done); end
      if (a_ready !== 1'b1) begin fails++; $display("FAIL dflt_post_ready got %b want 1", a_ready); end
   endtask

   task automatic test_gap();
      logic [7:0] p;
      logic       eb, ev, ed;
      p = 8'hC3;
      b_load = 1'b1; b_pat = p;
      step();
      b_load = 1'b0;
      b_start = 1'b1; b_rep = 4'd1;
      step();
      b_start = 1'b0;
      for (int i = 0; i < 19; i++) begin
         step();
         ed = 1'b0;
         if (i < 8)       begin eb = p[7-i];  ev = 1'b1; end
         else if (i < 10) begin eb = 1'b0;    ev = 1'b0; end
         else if (i < 18) begin eb = p[17-i]; ev = 1'b1; end
         else             begin eb = 1'b0;    ev = 1'b0; ed = 1'b1; end
         tests += 3;
         if (b_seq !== eb)  begin fails++; $display("FAIL gap_seq c%0d got %b want %b", i, b_seq, eb); end
         if (b_bv !== ev)   begin fails++; $display("FAIL gap_bv c%0d got %b want %b", i, b_bv, ev); end
         if (b_done !== ed) begin fails++; $display("FAIL gap_done c%0d got %b want %b", i, b_done, ed); end
      end
      step();
      tests++;
      if (b_ready !== 1'b1) begin fails++; $display("FAIL gap_ready got %b want 1", b_ready); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] p;
      p = 8'h5A;
      a_load = 1'b1; a_start = 1'b1; a_pat = p; a_rep = 4'd2;
      step();
      a_load = 1'b0; a_start = 1'b0;
      for (int i = 0; i < 24; i++) begin
         step();
         tests += 3;
         if (a_seq !== p[7-(i%8)]) begin fails++; $display("FAIL b2b_bit%0d got %b want %b", i, a_seq, p[7-(i%8)]); end
         if (a_bv !== 1'b1)        begin fails++; $display("FAIL b2b_bv%0d got %b want 1", i, a_bv); end
         if (a_done !== 1'b0)      begin fails++; $display("FAIL b2b_early_done%0d got %b want 0", i, a_done); end
      end
      step();
      tests += 2;
      if (a_done !== 1'b1) begin fails++; $display("FAIL b2b_done got %b want 1", a_done); end
      if (a_bv !== 1'b0)   begin fails++; $display("FAIL b2b_done_bv got %b want 0", a_bv); end
      step();
   endtask

   task automatic test_busy_ignore();
      logic [7:0] p;
      p = 8'h5A;
      a_start = 1'b1; a_rep = 4'd0;
      step();
      a_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin a_load = 1'b1; a_pat = 8'hFF; a_start = 1'b1; end
         step();
         a_load = 1'b0; a_start = 1'b0;
         tests++;
         if (a_seq !== p[7-i]) begin fails++; $display("FAIL busy_bit%0d got %b want %b", i, a_seq, p[7-i]); end
      end
      step();
      tests++;
      if (a_done !== 1'b1) begin fails++; $display("FAIL busy_done got %b want 1", a_done); end
      step();
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         tests++;
         if (a_seq !== p[7-i]) begin fails++; $display("FAIL busy_next_bit%0d got %b want %b", i, a_seq, p[7-i]); end
      end
      step();
      step();
   endtask

   task automatic test_abort();
      logic [7:0] p;
      logic       seen_done;
      p = 8'h5A;
      a_start = 1'b1; a_rep = 4'd0;
      step();
      a_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if (a_seq !== p[7-i]) begin fails++; $display("FAIL abort_pre_bit%0d got %b want %b", i, a_seq, p[7-i]); end
      end
      a_abort = 1'b1;
      step();
      a_abort = 1'b0;
      tests += 3;
      if (a_seq !== 1'b0)   begin fails++; $display("FAIL abort_seq got %b want 0", a_seq); end
      if (a_bv !== 1'b0)    begin fails++; $display("FAIL abort_bv got %b want 0", a_bv); end
      if (a_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", a_ready); end
      seen_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (a_done === 1'b1) seen_done = 1'b1;
      end
      tests++;
      if (seen_done !== 1'b0) begin fails++; $display("FAIL abort_no_done got %b want 0", seen_done); end
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         tests++;
         if (a_seq !== p[7-i]) begin fails++; $display("FAIL abort_retx_bit%0d got %b want %b", i, a_seq, p[7-i]); end
      end
      step();
      tests++;
      if (a_done !== 1'b1) begin fails++; $display("FAIL abort_retx_done got %b want 1", a_done); end
      step();
   endtask

   task automatic test_reset_mid();
      logic [7:0] p;
      p = 8'b10110101;
      a_load = 1'b1; a_pat = 8'h0F;
      step();
      a_load = 1'b0;
      a_start = 1'b1; a_rep = 4'd0;
      step();
      a_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if (a_seq !== a_pat[7-i]) begin fails++; $display("FAIL rmid_pre_bit%0d got %b want %b", i, a_seq, a_pat[7-i]); end
      end
      a_rst = 1'b1;
      step();
      a_rst = 1'b0;
      tests += 4;
      if (a_seq !== 1'b0)   begin fails++; $display("FAIL rmid_seq got %b want 0", a_seq); end
      if (a_bv !== 1'b0)    begin fails++; $display("FAIL rmid_bv got %b want 0", a_bv); end
      if (a_done !== 1'b0)  begin fails++; $display("FAIL rmid_done got %b want 0", a_done); end
      if (a_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %b want 1", a_ready); end
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         tests++;
         if (a_seq !== p[7-i]) begin fails++; $display("FAIL rmid_dflt_bit%0d got %b want %b", i, a_seq, p[7-i]); end
      end
      step();
      tests++;
      if (a_done !== 1'b1) begin fails++; $display("FAIL rmid_dflt_done got %b want 1", a_done); end
      step();
   endtask

   initial begin
      tests = 0; fails = 0;
      a_rst = 1'b1; a_load = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_pat = '0; a_rep = '0;
      b_rst = 1'b1; b_load = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_pat = '0; b_rep = '0;
      test_reset();
      test_default_frame();
      test_gap();
      test_back_to_back();
      test_busy_ignore();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
